// File: rtl/bitmap_fill_writer_pkg.sv
// rtl/bitmap_fill_writer_pkg.sv - shared types and bitmap geometry defaults for the fill writer
package bitmap_pkg;

   // Geometry shared with the dual-port bitmap RAM and the VGA reader
   localparam int BM_NLOC  = 1024;
   localparam int BM_DBITS = 12;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      DONE
   } bfw_state_t;

   typedef enum logic {
      OP_SINGLE = 1'b0,
      OP_FILL   = 1'b1
   } bfw_op_t;

endpackage

// File: rtl/bitmap_fill_writer_if.sv
// rtl/bitmap_fill_writer_if.sv - command and bitmap write-port bundle for the fill writer
interface bitmap_fill_writer_if
   import bitmap_pkg::*;
#(
   parameter int NLOC  = BM_NLOC,
   parameter int DBITS = BM_DBITS
) ();

   localparam int AW = $clog2(NLOC);

   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_op;
   logic [AW-1:0]    cmd_addr;
   logic [AW:0]      cmd_len;
   logic [DBITS-1:0] cmd_color;
   logic             bm_we;
   logic [AW-1:0]    bm_addr;
   logic [DBITS-1:0] bm_wdata;
   logic             busy;
   logic             done;
   logic             clip_err;

   // Command issuer (processor MMIO side)
   modport master (
      output cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_color,
      input  cmd_ready, bm_we, bm_addr, bm_wdata, busy, done, clip_err
   );

   // Fill writer engine
   modport slave (
      input  cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_color,
      output cmd_ready, bm_we, bm_addr, bm_wdata, busy, done, clip_err
   );

endinterface

// File: rtl/bitmap_fill_writer.sv
// rtl/bitmap_fill_writer.sv - single-pixel / run-fill write engine for the bitmap RAM (optional BITMAP_FILL_WRITER_CNT_EN write counter)
module bitmap_fill_writer
   import bitmap_pkg::*;
#(
   parameter int Nloc  = BM_NLOC,
   parameter int Dbits = BM_DBITS
) (
   input  logic                  clk,
   input  logic                  reset_n,
   bitmap_fill_writer_if.slave   bus
`ifdef BITMAP_FILL_WRITER_CNT_EN
   ,
   input  logic                  cnt_clr,
   output logic [15:0]           wr_count
`endif
);

   localparam int AW = $clog2(Nloc);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] NLOC_L    = LW'(Nloc);
   localparam logic [LW-1:0] LAST_ADDR = LW'(Nloc - 1);

   bfw_state_t       r_state, w_next_state;
   logic [AW-1:0]    r_cur, w_next_cur;
   logic [LW-1:0]    r_rem, w_next_rem;
   logic [Dbits-1:0] r_color, w_next_color;
   logic             r_clip, w_next_clip;
   logic             r_we, r_done, r_busy, r_ready;
   logic [LW-1:0]    w_eff_len;
   logic             w_accept;
   logic             w_last;

   // Next-state, counters and clip flag; address compares are widened so Nloc-1 never wraps
   always_comb begin
      w_next_state = r_state;
      w_next_cur   = r_cur;
      w_next_rem   = r_rem;
      w_next_color = r_color;
      w_next_clip  = r_clip;
      w_eff_len    = (bfw_op_t'(bus.cmd_op) == OP_FILL) ? bus.cmd_len : LW'(1);
      w_accept     = bus.cmd_valid && (r_state == IDLE);
      w_last       = (r_rem <= LW'(1)) || ({1'b0, r_cur} == LAST_ADDR);

      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_next_clip = 1'b0;
               if ({1'b0, bus.cmd_addr} >= NLOC_L) begin
                  w_next_clip  = 1'b1;
                  w_next_state = DONE;
               end else if (w_eff_len == '0) begin
                  w_next_state = DONE;
               end else begin
                  w_next_cur   = bus.cmd_addr;
                  w_next_rem   = w_eff_len;
                  w_next_color = bus.cmd_color;
                  w_next_state = WRITE;
               end
            end
         end
         WRITE: begin
            if (w_last) begin
               // Hitting the end of the bitmap with pixels still owed truncates the run
               if (r_rem > LW'(1)) begin
                  w_next_clip = 1'b1;
               end
               w_next_state = DONE;
            end else begin
               w_next_cur = r_cur + AW'(1);
               w_next_rem = r_rem - LW'(1);
            end
         end
         DONE: begin
            w_next_state = IDLE;
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // State, datapath and registered status outputs derived from the next state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_cur   <= '0;
         r_rem   <= '0;
         r_color <= '0;
         r_clip  <= 1'b0;
         r_we    <= 1'b0;
         r_done  <= 1'b0;
         r_busy  <= 1'b0;
         r_ready <= 1'b1;
      end else begin
         r_state <= w_next_state;
         r_cur   <= w_next_cur;
         r_rem   <= w_next_rem;
         r_color <= w_next_color;
         r_clip  <= w_next_clip;
         r_we    <= (w_next_state == WRITE);
         r_done  <= (w_next_state == DONE);
         r_busy  <= (w_next_state != IDLE);
         r_ready <= (w_next_state == IDLE);
      end
   end

   assign bus.cmd_ready = r_ready;
   assign bus.bm_we     = r_we;
   assign bus.bm_addr   = r_cur;
   assign bus.bm_wdata  = r_color;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.clip_err  = r_clip;

`ifdef BITMAP_FILL_WRITER_CNT_EN
   logic [15:0] r_wr_count;

   // Saturating count of write cycles; clear wins over increment
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_count <= '0;
      end else if (cnt_clr) begin
         r_wr_count <= '0;
      end else if (r_we && (r_wr_count != 16'hFFFF)) begin
         r_wr_count <= r_wr_count + 16'd1;
      end
   end

   assign wr_count = r_wr_count;
`endif

endmodule

// File: tb/tb_bitmap_fill_writer.sv
// tb/tb_bitmap_fill_writer.sv - self-checking bench for bitmap_fill_writer with a behavioural bitmap model
module tb_bitmap_fill_writer;
   import bitmap_pkg::*;

   localparam int NLOC  = BM_NLOC;
   localparam int DBITS = BM_DBITS;
   localparam int AW    = $clog2(NLOC);

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   bitmap_fill_writer_if #(.NLOC(NLOC), .DBITS(DBITS)) bus ();

`ifdef BITMAP_FILL_WRITER_CNT_EN
   logic        cnt_clr = 1'b0;
   logic [15:0] wr_count;
   bitmap_fill_writer #(.Nloc(NLOC), .Dbits(DBITS)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus), .cnt_clr(cnt_clr), .wr_count(wr_count));
`else
   bitmap_fill_writer #(.Nloc(NLOC), .Dbits(DBITS)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus));
`endif

   int n_checks = 0;
   int n_pass = 0;

   int obs_addr[$];
   int obs_data[$];
   int done_cnt = 0;
   int tb_ram[NLOC];
   int ref_mem[NLOC];

   // Bitmap RAM stand-in: records every write seen on the port
   always @(negedge clk) begin
      if (bus.bm_we === 1'b1) begin
         obs_addr.push_back(int'(bus.bm_addr));
         obs_data.push_back(int'(bus.bm_wdata));
         tb_ram[bus.bm_addr] = int'(bus.bm_wdata);
      end
      if (bus.done === 1'b1) done_cnt++;
   end

   // Reference: a run covers addr..min(addr+len, NLOC)-1; clipped if it wanted more
   task automatic model_cmd(input int op, input int addr, input int len, input int color,
                            output int nw, output int clip);
      int eff;
      eff = (op != 0) ? len : 1;
      if (addr >= NLOC) begin
         nw = 0; clip = 1;
      end else begin
         clip = (addr + eff > NLOC) ? 1 : 0;
         nw   = (addr + eff > NLOC) ? NLOC - addr : eff;
      end
      for (int k = 0; k < nw; k++) ref_mem[addr + k] = color;
   endtask

   task automatic issue(input int op, input int addr, input int len, input int color, output bit tmo);
      tmo = 0;
      @(negedge clk);
      for (int i = 0; i < 3000 && bus.cmd_ready !== 1'b1; i++) @(negedge clk);
      if (bus.cmd_ready !== 1'b1) tmo = 1;
      bus.cmd_op    = op[0];
      bus.cmd_addr  = AW'(addr);
      bus.cmd_len   = (AW + 1)'(len);
      bus.cmd_color = DBITS'(color);
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
   endtask

   // Issue one command and return the index (0 = cycle after accept) of its done pulse
   task automatic run_cmd(input int op, input int addr, input int len, input int color,
                          output int lat, output bit tmo);
      obs_addr.delete();
      obs_data.delete();
      lat = -1;
      issue(op, addr, len, color, tmo);
      for (int i = 0; i < 3000; i++) begin
         if (bus.done === 1'b1) begin
            lat = i;
            break;
         end
         @(negedge clk);
      end
      if (lat < 0) tmo = 1;
   endtask

   task automatic test_reset();
      bit tmo;
      int d0;
      bit bad;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({bus.bm_we, bus.busy, bus.done, bus.clip_err, bus.cmd_ready} !== 5'b00001)
         $display("FAIL reset_state: got %b expected 00001", {bus.bm_we, bus.busy, bus.done, bus.clip_err, bus.cmd_ready});
      else n_pass++;
      reset_n = 1'b1;
      obs_addr.delete();
      obs_data.delete();
      d0 = done_cnt;
      issue(1, 10, 20, 12'h5A5, tmo);
      repeat (4) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      n_checks++;
      if ({bus.bm_we, bus.busy, bus.cmd_ready} !== 3'b001 || tmo)
         $display("FAIL reset_abort_outputs: got we/busy/ready=%b expected 001", {bus.bm_we, bus.busy, bus.cmd_ready});
      else n_pass++;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      n_checks++;
      if (done_cnt !== d0) $display("FAIL reset_no_done: got %0d done pulses expected 0", done_cnt - d0);
      else n_pass++;
      bad = (obs_addr.size() != 5);
      for (int k = 0; k < obs_addr.size() && !bad; k++)
         if (obs_addr[k] != 10 + k || obs_data[k] != 12'h5A5) bad = 1;
      n_checks++;
      if (bad) $display("FAIL reset_written_span: got %0d writes expected 5 at 10..14", obs_addr.size());
      else n_pass++;
      for (int k = 10; k < 15; k++) ref_mem[k] = 12'h5A5;
   endtask

   task automatic test_single();
      int lat, nw, clip;
      bit tmo;
      run_cmd(0, 12'h123, $urandom_range(0, 1024), 12'hF00, lat, tmo);
      model_cmd(0, 12'h123, 0, 12'hF00, nw, clip);
      n_checks++;
      if (lat !== 1 || tmo) $display("FAIL single_done_latency: got %0d expected 1", lat);
      else n_pass++;
      n_checks++;
      if (obs_addr.size() != 1 || obs_addr[0] != 12'h123 || obs_data[0] != 12'hF00)
         $display("FAIL single_write: got %0d writes first addr %0h expected 1 write 123/F00",
                  obs_addr.size(), (obs_addr.size() > 0) ? obs_addr[0] : -1);
      else n_pass++;
      n_checks++;
      if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1)
         $display("FAIL single_ready_in_done: got ready=%b busy=%b expected 0/1", bus.cmd_ready, bus.busy);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (bus.cmd_ready !== 1'b1 || bus.done !== 1'b0 || bus.busy !== 1'b0)
         $display("FAIL single_ready_after: got ready=%b done=%b busy=%b expected 1/0/0", bus.cmd_ready, bus.done, bus.busy);
      else n_pass++;
   endtask

   task automatic test_random();
      int op, addr, len, color, lat, nw, clip;
      bit tmo, bad;
      for (int c = 0; c < 12; c++) begin
         op    = $urandom_range(0, 1);
         addr  = ($urandom_range(0, 3) == 0) ? $urandom_range(NLOC - 40, NLOC - 1) : $urandom_range(0, NLOC - 1);
         len   = $urandom_range(0, 48);
         color = $urandom_range(0, (1 << DBITS) - 1);
         run_cmd(op, addr, len, color, lat, tmo);
         model_cmd(op, addr, len, color, nw, clip);
         bad = (obs_addr.size() != nw);
         for (int k = 0; k < obs_addr.size() && !bad; k++)
            if (obs_addr[k] != addr + k || obs_data[k] != color) bad = 1;
         n_checks++;
         if (bad || tmo || lat != nw || int'(bus.clip_err) != clip)
            $display("FAIL random_cmd%0d: op=%0d addr=%0d len=%0d got writes=%0d lat=%0d clip=%b expected writes=%0d lat=%0d clip=%0d",
                     c, op, addr, len, obs_addr.size(), lat, bus.clip_err, nw, nw, clip);
         else n_pass++;
      end
   endtask

   task automatic test_full_fill();
      int lat, nw, clip;
      bit tmo, bad;
      run_cmd(1, 0, NLOC, 0, lat, tmo);
      model_cmd(1, 0, NLOC, 0, nw, clip);
      n_checks++;
      if (lat !== NLOC || tmo) $display("FAIL full_fill_latency: got %0d expected %0d", lat, NLOC);
      else n_pass++;
      bad = (obs_addr.size() != NLOC);
      for (int k = 0; k < obs_addr.size() && !bad; k++)
         if (obs_addr[k] != k || obs_data[k] != 0) bad = 1;
      n_checks++;
      if (bad) $display("FAIL full_fill_order: got %0d writes expected %0d in order", obs_addr.size(), NLOC);
      else n_pass++;
      n_checks++;
      if (bus.clip_err !== 1'b0) $display("FAIL full_fill_clip: got %b expected 0", bus.clip_err);
      else n_pass++;
      bad = 0;
      for (int k = 0; k < NLOC; k++) if (tb_ram[k] != 0 || ref_mem[k] != 0) bad = 1;
      n_checks++;
      if (bad) $display("FAIL full_fill_readback: got nonzero pixel expected all 000");
      else n_pass++;
   endtask

   task automatic test_clip();
      int lat, nw, clip;
      bit tmo, bad;
      run_cmd(1, NLOC - 4, 8, 12'h0F0, lat, tmo);
      model_cmd(1, NLOC - 4, 8, 12'h0F0, nw, clip);
      bad = (obs_addr.size() != 4);
      for (int k = 0; k < obs_addr.size() && !bad; k++)
         if (obs_addr[k] != NLOC - 4 + k) bad = 1;
      n_checks++;
      if (bad || lat !== 4 || tmo) $display("FAIL clip_truncate: got %0d writes lat=%0d expected 4/4", obs_addr.size(), lat);
      else n_pass++;
      n_checks++;
      if (bus.clip_err !== 1'b1 || clip != 1) $display("FAIL clip_set: got %b expected 1", bus.clip_err);
      else n_pass++;
      run_cmd(0, 5, 0, 12'h00F, lat, tmo);
      model_cmd(0, 5, 0, 12'h00F, nw, clip);
      n_checks++;
      if (bus.clip_err !== 1'b0 || tmo) $display("FAIL clip_cleared: got %b expected 0", bus.clip_err);
      else n_pass++;
   endtask

   task automatic test_len0();
      int lat, nw, clip;
      bit tmo;
      run_cmd(1, $urandom_range(0, NLOC - 1), 0, 12'hABC, lat, tmo);
      n_checks++;
      if (lat !== 0 || tmo || obs_addr.size() != 0 || bus.clip_err !== 1'b0)
         $display("FAIL len0: got lat=%0d writes=%0d clip=%b expected 0/0/0", lat, obs_addr.size(), bus.clip_err);
      else n_pass++;
      model_cmd(1, 0, 0, 0, nw, clip);
   endtask

   task automatic test_back_to_back();
      int idx[$];
      int adr[$];
      int exp_idx[6] = '{0, 1, 2, 5, 6, 7};
      int exp_adr[6] = '{100, 101, 102, 200, 201, 202};
      int d0, nw, clip;
      bit bad;
      @(negedge clk);
      for (int i = 0; i < 3000 && bus.cmd_ready !== 1'b1; i++) @(negedge clk);
      d0 = done_cnt;
`ifdef BITMAP_FILL_WRITER_CNT_EN
      cnt_clr = 1'b1;
`endif
      bus.cmd_op = 1'b1; bus.cmd_addr = AW'(100); bus.cmd_len = (AW + 1)'(3);
      bus.cmd_color = 12'h111; bus.cmd_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
`ifdef BITMAP_FILL_WRITER_CNT_EN
         cnt_clr = 1'b0;
`endif
         if (bus.bm_we === 1'b1) begin
            idx.push_back(i);
            adr.push_back(int'(bus.bm_addr));
            if (bus.bm_addr == AW'(200)) bus.cmd_valid = 1'b0;
         end
         if (bus.busy === 1'b1 && bus.cmd_addr == AW'(100)) begin
            bus.cmd_addr = AW'(200); bus.cmd_color = 12'h222;
         end
      end
      bus.cmd_valid = 1'b0;
      model_cmd(1, 100, 3, 12'h111, nw, clip);
      model_cmd(1, 200, 3, 12'h222, nw, clip);
      bad = (idx.size() != 6);
      for (int k = 0; k < idx.size() && !bad; k++)
         if (idx[k] != exp_idx[k] || adr[k] != exp_adr[k]) bad = 1;
      n_checks++;
      if (bad) $display("FAIL b2b_timing: got %0d writes second start idx=%0d expected 6 with second at 5",
                        idx.size(), (idx.size() > 3) ? idx[3] : -1);
      else n_pass++;
      n_checks++;
      if (done_cnt - d0 != 2) $display("FAIL b2b_done_count: got %0d expected 2", done_cnt - d0);
      else n_pass++;
`ifdef BITMAP_FILL_WRITER_CNT_EN
      n_checks++;
      if (wr_count !== 16'd6) $display("FAIL wr_count: got %0d expected 6", wr_count);
      else n_pass++;
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
      n_checks++;
      if (wr_count !== 16'd0) $display("FAIL wr_count_clr: got %0d expected 0", wr_count);
      else n_pass++;
`endif
   endtask

   task automatic test_ram_image();
      int diffs;
      diffs = 0;
      for (int k = 0; k < NLOC; k++) if (tb_ram[k] != ref_mem[k]) diffs++;
      n_checks++;
      if (diffs != 0) $display("FAIL ram_image: got %0d differing pixels expected 0", diffs);
      else n_pass++;
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_len   = '0;
      bus.cmd_color = '0;
      for (int k = 0; k < NLOC; k++) begin
         tb_ram[k]  = 0;
         ref_mem[k] = 0;
      end
      test_reset();
      test_single();
      test_random();
      test_ram_image();
      test_full_fill();
      test_clip();
      test_len0();
      test_back_to_back();
      test_ram_image();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
